// File: rtl/ram_block_mover.sv
// Block copy / block fill initiator for a single-port ram (cs/oe/wr, sampled on negedge clk).
// One ram access per cycle. Every output is registered and is computed from the next state.
module ram_block_mover #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_cs,
    output logic                  ram_oe,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;     // next source address to read
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;     // next destination address to write
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;     // writes not yet presented
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cs_q, cs_d;
    logic                  oe_q, oe_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // Next state plus the ram access to present during the next cycle.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cs_d    = 1'b0;
        oe_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    fill_d = fill_value;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    rem_d  = length;
                    if (length == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else if (mode) begin
                        state_d = WR;
                        busy_d  = 1'b1;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = dst_addr;
                        din_d   = fill_value;
                        dst_d   = dst_addr + ADDR_ONE;
                        rem_d   = length - LEN_ONE;
                    end else begin
                        state_d = RD;
                        busy_d  = 1'b1;
                        cs_d    = 1'b1;
                        oe_d    = 1'b1;
                        addr_d  = src_addr;
                        src_d   = src_addr + ADDR_ONE;
                    end
                end
            end
            RD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // ram_q holds the word read during this cycle
                    state_d = WR;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = dst_q;
                    din_d   = ram_q;
                    dst_d   = dst_q + ADDR_ONE;
                    rem_d   = rem_q - LEN_ONE;
                end
            end
            WR: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (rem_q == '0) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else if (mode_q) begin
                    state_d = WR;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = dst_q;
                    din_d   = fill_q;
                    dst_d   = dst_q + ADDR_ONE;
                    rem_d   = rem_q - LEN_ONE;
                end else begin
                    state_d = RD;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    oe_d    = 1'b1;
                    addr_d  = src_q;
                    src_d   = src_q + ADDR_ONE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_cs   = cs_q;
    assign ram_oe   = oe_q;
    assign ram_wr   = wr_q;
    assign ram_addr = addr_q;
    assign ram_din  = din_q;

endmodule

// File: tb/tb_ram_block_mover.sv
// Directed bench for ram_block_mover with a negedge-sampled ram model.
module tb_ram_block_mover;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        mode;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] length;
    logic [7:0]  fill_value;
    logic        busy;
    logic        done;
    logic        ram_cs;
    logic        ram_oe;
    logic        ram_wr;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_q;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] wr_log [$];
    int          cs_count = 0;

    ram_block_mover #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .LEN_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .fill_value(fill_value),
        .busy      (busy),
        .done      (done),
        .ram_cs    (ram_cs),
        .ram_oe    (ram_oe),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ram model: preload, then serve accesses on negedge; logs writes and chip selects.
    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0100] = 8'h11;
        mem[16'h0101] = 8'h22;
        mem[16'h0102] = 8'h33;
        for (int a = 0; a < 8; a++) mem[16'h0300 + a] = 8'(8'hC0 + a);
        ram_q = 8'h00;
        forever begin
            @(negedge clk);
            if (ram_cs) cs_count++;
            if (ram_cs && ram_wr) begin
                mem[ram_addr] = ram_din;
                wr_log.push_back(ram_addr);
            end
            if (ram_cs && ram_oe) ram_q = mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [7:0] f);
        mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_tests++;
        if ({busy, done, ram_cs, ram_oe, ram_wr} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, ram_cs, ram_oe, ram_wr});
        end
        n_tests++;
        if (ram_addr !== 16'h0000 || ram_din !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %h din %h want 0000 00", ram_addr, ram_din);
        end
    endtask

    task automatic test_fill();
        int base = wr_log.size();
        launch(1'b1, 16'h0000, 16'h0010, 16'd4, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({ram_cs, ram_oe, ram_wr, busy} !== 4'b1011 || ram_addr !== 16'(16'h0010 + i)
                || ram_din !== 8'h5A) begin
                n_fail++;
                $display("FAIL fill_wr%0d: got cs/oe/wr/busy %b addr %h din %h want 1011 %h 5a",
                         i, {ram_cs, ram_oe, ram_wr, busy}, ram_addr, ram_din, 16'(16'h0010 + i));
            end
            tick();
        end
        n_tests++;
        if ({done, busy, ram_cs} !== 3'b100) begin
            n_fail++;
            $display("FAIL fill_done: got done/busy/cs %b want 100", {done, busy, ram_cs});
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done_pulse: got %b want 0", done);
        end
        n_tests++;
        if (mem[16'h0010] !== 8'h5A || mem[16'h0013] !== 8'h5A || mem[16'h0014] !== 8'h00
            || wr_log.size() - base != 4) begin
            n_fail++;
            $display("FAIL fill_mem: got %h %h %h writes %0d want 5a 5a 00 4",
                     mem[16'h0010], mem[16'h0013], mem[16'h0014], wr_log.size() - base);
        end
    endtask

    task automatic test_copy();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        launch(1'b0, 16'h0100, 16'h0200, 16'd3, 8'h00);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({ram_cs, ram_oe, ram_wr, busy} !== 4'b1101 || ram_addr !== 16'(16'h0100 + k)) begin
                n_fail++;
                $display("FAIL copy_rd%0d: got cs/oe/wr/busy %b addr %h want 1101 %h",
                         k, {ram_cs, ram_oe, ram_wr, busy}, ram_addr, 16'(16'h0100 + k));
            end
            tick();
            n_tests++;
            if ({ram_cs, ram_oe, ram_wr, busy} !== 4'b1011 || ram_addr !== 16'(16'h0200 + k)
                || ram_din !== exp_d[k]) begin
                n_fail++;
                $display("FAIL copy_wr%0d: got cs/oe/wr/busy %b addr %h din %h want 1011 %h %h",
                         k, {ram_cs, ram_oe, ram_wr, busy}, ram_addr, ram_din,
                         16'(16'h0200 + k), exp_d[k]);
            end
            tick();
        end
        n_tests++;
        if ({done, busy, ram_cs} !== 3'b100) begin
            n_fail++;
            $display("FAIL copy_done: got done/busy/cs %b want 100", {done, busy, ram_cs});
        end
        tick();
        n_tests++;
        if (mem[16'h0200] !== 8'h11 || mem[16'h0201] !== 8'h22 || mem[16'h0202] !== 8'h33) begin
            n_fail++;
            $display("FAIL copy_mem: got %h %h %h want 11 22 33",
                     mem[16'h0200], mem[16'h0201], mem[16'h0202]);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        int base = wr_log.size();
        int cyc  = 0;
        launch(1'b1, 16'h0000, 16'hFFFE, 16'd4, 8'hA5);
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_timeout: got done %b after %0d cycles want 1", done, cyc);
        end
        tick();
        n_tests++;
        if (wr_log.size() - base != 4) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes want 4", wr_log.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (wr_log[base + i] !== exp_a[i] || mem[exp_a[i]] !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL wrap_addr%0d: got %h data %h want %h a5",
                             i, wr_log[base + i], mem[exp_a[i]], exp_a[i]);
                end
            end
        end
        n_tests++;
        if (mem[16'hFFFD] !== 8'h00 || mem[16'h0002] !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_neighbours: got %h %h want 00 00", mem[16'hFFFD], mem[16'h0002]);
        end
    endtask

    task automatic test_len_zero();
        int base_cs = cs_count;
        launch(1'b0, 16'h0100, 16'h0900, 16'd0, 8'h00);
        n_tests++;
        if ({done, busy, ram_cs} !== 3'b100) begin
            n_fail++;
            $display("FAIL len0_done: got done/busy/cs %b want 100", {done, busy, ram_cs});
        end
        tick();
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL len0_after: got done/busy %b want 00", {done, busy});
        end
        tick();
        n_tests++;
        if (cs_count != base_cs || mem[16'h0900] !== 8'h00) begin
            n_fail++;
            $display("FAIL len0_noaccess: got %0d cs cycles mem %h want 0 00",
                     cs_count - base_cs, mem[16'h0900]);
        end
    endtask

    task automatic test_abort();
        int base = wr_log.size();
        int done_seen = 0;
        launch(1'b0, 16'h0300, 16'h0400, 16'd8, 8'h00);
        tick();
        tick();
        tick();
        n_tests++;
        if (ram_wr !== 1'b1 || ram_addr !== 16'h0401) begin
            n_fail++;
            $display("FAIL abort_2nd_wr: got wr %b addr %h want 1 0401", ram_wr, ram_addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if ({busy, done, ram_cs, ram_oe, ram_wr} !== 5'b00000) begin
            n_fail++;
            $display("FAIL abort_idle: got %b want 00000", {busy, done, ram_cs, ram_oe, ram_wr});
        end
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        n_tests++;
        if (done_seen != 0 || wr_log.size() - base != 2) begin
            n_fail++;
            $display("FAIL abort_result: got done %0d writes %0d want 0 2",
                     done_seen, wr_log.size() - base);
        end
        n_tests++;
        if (mem[16'h0400] !== 8'hC0 || mem[16'h0401] !== 8'hC1 || mem[16'h0402] !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_mem: got %h %h %h want c0 c1 00",
                     mem[16'h0400], mem[16'h0401], mem[16'h0402]);
        end
        launch(1'b1, 16'h0000, 16'h0500, 16'd1, 8'h77);
        n_tests++;
        if (ram_wr !== 1'b1 || ram_addr !== 16'h0500 || ram_din !== 8'h77) begin
            n_fail++;
            $display("FAIL abort_restart_wr: got wr %b addr %h din %h want 1 0500 77",
                     ram_wr, ram_addr, ram_din);
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || mem[16'h0500] !== 8'h77) begin
            n_fail++;
            $display("FAIL abort_restart_done: got done %b mem %h want 1 77", done, mem[16'h0500]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int base = wr_log.size();
        launch(1'b0, 16'h0100, 16'h0600, 16'd3, 8'h00);
        tick();
        mode = 1'b1; dst_addr = 16'h0700; length = 16'd2; fill_value = 8'hEE;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: got %b want 1 at T+7", done);
        end
        mode = 1'b1; dst_addr = 16'h0700; length = 16'd1; fill_value = 8'hEE;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({busy, done, ram_cs} !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_fin_start: got busy/done/cs %b want 000", {busy, done, ram_cs});
        end
        tick();
        tick();
        n_tests++;
        if (wr_log.size() - base != 3 || mem[16'h0700] !== 8'h00 || mem[16'h0602] !== 8'h33) begin
            n_fail++;
            $display("FAIL b2b_mem: got writes %0d mem700 %h mem602 %h want 3 00 33",
                     wr_log.size() - base, mem[16'h0700], mem[16'h0602]);
        end
    endtask

    task automatic test_reset_mid();
        int base = wr_log.size();
        int base_cs;
        launch(1'b0, 16'h0100, 16'h0800, 16'd8, 8'h00);
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if ({busy, done, ram_cs, ram_oe, ram_wr} !== 5'b00000 || ram_addr !== 16'h0000
            || ram_din !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b addr %h din %h want 00000 0000 00",
                     {busy, done, ram_cs, ram_oe, ram_wr}, ram_addr, ram_din);
        end
        reset = 1'b0;
        base_cs = cs_count;
        for (int i = 0; i < 12; i++) tick();
        n_tests++;
        if (cs_count != base_cs || wr_log.size() - base != 1 || mem[16'h0801] !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_quiet: got cs %0d writes %0d mem801 %h want 0 1 00",
                     cs_count - base_cs, wr_log.size() - base, mem[16'h0801]);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
        test_reset();
        test_fill();
        test_copy();
        test_wrap();
        test_len_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
